// File: rtl/iso7816_pkg.sv
// Shared constants for the ISO7816 character receiver.
//   - Receiver state encoding (plain localparams so legacy tools can read them)
//   - Character geometry: data bit count
//   - Error-signal (io_oe) duration in etu
package iso7816_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned ERR_ETU   = 1;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_START  = 3'd1;
    localparam state_t S_DATA   = 3'd2;
    localparam state_t S_PARITY = 3'd3;
    localparam state_t S_GUARD  = 3'd4;
    localparam state_t S_ERR    = 3'd5;

endpackage

// File: rtl/iso7816_rx_char_if.sv
// Character result bundle of the ISO7816 receiver.
//   out_data : received byte, decoded to the selected convention
//   out_stb  : one-cycle pulse, result valid
//   out_perr : parity error on the character
//   out_ferr : guard sample found the line low
// master = receiver side (drives), slave = consumer side.
interface iso7816_rx_char_if;

    logic [7:0] out_data;
    logic       out_stb;
    logic       out_perr;
    logic       out_ferr;

    modport master (
        output out_data,
        output out_stb,
        output out_perr,
        output out_ferr
    );

    modport slave (
        input out_data,
        input out_stb,
        input out_perr,
        input out_ferr
    );

endinterface

// File: rtl/iso7816_sync_in.sv
// I/O line synchronizer with falling-edge detect.
//   clk, rst : clock and synchronous active-high reset
//   io_in    : asynchronous line level
//   line     : synchronized line level
//   fall     : one-cycle pulse on a synchronized high-to-low transition
// Flops reset to 1 (idle line) so a line that is low at reset release
// does not look like a start edge.
module iso7816_sync_in #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic io_in,
    output logic line,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], io_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign line = sync_q[SYNC_STAGES-1];
    assign fall = prev_q & ~line;

endmodule

// File: rtl/iso7816_rx_char.sv
// ISO7816 character receiver.
//   clk, rst          : clock, synchronous active-high reset
//   io_in / io_oe     : I/O line level in; io_oe=1 pulls the line low (error signal)
//   stb_rx            : mid-bit sample strobe from the baud generator
//   brg_sync/run/txrx : baud generator phase-align pulse, run enable, direction (0=rx)
//   cfg_inverse, en   : inverse convention select, receive enable
//   out_if            : character result (data, strobe, parity/framing errors)
// Build option: define ISO7816_RX_ERRSIG_EN to include the ERR state and the
// io_oe error-signal drive; otherwise io_oe is tied low and parity errors are
// only reported on out_perr.
module iso7816_rx_char
    import iso7816_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     io_in,
    output logic                     io_oe,
    input  logic                     stb_rx,
    output logic                     brg_sync,
    output logic                     brg_run,
    output logic                     brg_txrx,
    input  logic                     cfg_inverse,
    input  logic                     en,
    iso7816_rx_char_if.master        out_if
);

    logic line, fall, bit_val;

    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shreg_q, shreg_d;
    logic       par_q, par_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_stb_q, out_stb_d;
    logic       out_perr_q, out_perr_d;
    logic       out_ferr_q, out_ferr_d;
`ifdef ISO7816_RX_ERRSIG_EN
    logic       io_oe_q, io_oe_d;
    logic [1:0] etu_cnt_q, etu_cnt_d;
`endif

    iso7816_sync_in #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .io_in(io_in),
        .line (line),
        .fall (fall)
    );

    // Inverse convention: line low = 1
    assign bit_val = line ^ cfg_inverse;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        par_d      = par_q;
        out_data_d = out_data_q;
        out_stb_d  = 1'b0;
        out_perr_d = out_perr_q;
        out_ferr_d = out_ferr_q;
`ifdef ISO7816_RX_ERRSIG_EN
        io_oe_d    = io_oe_q;
        etu_cnt_d  = etu_cnt_q;
`endif
        if (state_q != S_IDLE && !en) begin
            // Abort beats any coincident sample strobe
            state_d = S_IDLE;
`ifdef ISO7816_RX_ERRSIG_EN
            io_oe_d = 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (en && fall) state_d = S_START;
                end
                S_START: begin
                    if (stb_rx) begin
                        if (!line) begin
                            state_d   = S_DATA;
                            bit_cnt_d = '0;
                            par_d     = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_DATA: begin
                    if (stb_rx) begin
                        // Direct: LSB first, shift right. Inverse: MSB first, shift left.
                        shreg_d = cfg_inverse ? {shreg_q[6:0], bit_val}
                                              : {bit_val, shreg_q[7:1]};
                        par_d   = par_q ^ bit_val;
                        if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                            state_d   = S_PARITY;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    // First strobe samples the parity bit, second (10.5 etu) decides.
                    if (stb_rx) begin
                        if (bit_cnt_q == 3'd0) begin
                            par_d     = par_q ^ bit_val;
                            bit_cnt_d = 3'd1;
                        end else begin
                            state_d = S_GUARD;
`ifdef ISO7816_RX_ERRSIG_EN
                            if (par_q) begin
                                state_d    = S_ERR;
                                io_oe_d    = 1'b1;
                                etu_cnt_d  = '0;
                                out_stb_d  = 1'b1;
                                out_data_d = shreg_q;
                                out_perr_d = 1'b1;
                                out_ferr_d = 1'b0;
                            end
`endif
                        end
                    end
                end
                S_GUARD: begin
                    if (stb_rx) begin
                        state_d    = S_IDLE;
                        out_stb_d  = 1'b1;
                        out_data_d = shreg_q;
                        out_perr_d = par_q;
                        out_ferr_d = ~line;
                    end
                end
`ifdef ISO7816_RX_ERRSIG_EN
                S_ERR: begin
                    if (stb_rx) begin
                        if (etu_cnt_q == 2'(ERR_ETU - 1)) begin
                            state_d = S_IDLE;
                            io_oe_d = 1'b0;
                        end else begin
                            etu_cnt_d = etu_cnt_q + 2'd1;
                        end
                    end
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            par_q      <= 1'b0;
            out_data_q <= '0;
            out_stb_q  <= 1'b0;
            out_perr_q <= 1'b0;
            out_ferr_q <= 1'b0;
`ifdef ISO7816_RX_ERRSIG_EN
            io_oe_q    <= 1'b0;
            etu_cnt_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            par_q      <= par_d;
            out_data_q <= out_data_d;
            out_stb_q  <= out_stb_d;
            out_perr_q <= out_perr_d;
            out_ferr_q <= out_ferr_d;
`ifdef ISO7816_RX_ERRSIG_EN
            io_oe_q    <= io_oe_d;
            etu_cnt_q  <= etu_cnt_d;
`endif
        end
    end

    assign brg_sync = ~rst & en & fall & (state_q == S_IDLE);
    assign brg_run  = (state_q != S_IDLE);
    assign brg_txrx = 1'b0;
`ifdef ISO7816_RX_ERRSIG_EN
    assign io_oe = io_oe_q;
`else
    assign io_oe = 1'b0;
`endif

    assign out_if.out_data = out_data_q;
    assign out_if.out_stb  = out_stb_q;
    assign out_if.out_perr = out_perr_q;
    assign out_if.out_ferr = out_ferr_q;

endmodule

// File: tb/tb_iso7816_rx_char.sv
// Directed bench for iso7816_rx_char with a behavioural baud generator
// (1 etu = 372 clk, sample strobe at mid-bit after brg_sync).
module tb_iso7816_rx_char;

    localparam int ETU = 372;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic io_in = 1'b1;
    logic cfg_inverse = 1'b0;
    logic en = 1'b1;
    logic io_oe, stb_rx, brg_sync, brg_run, brg_txrx;

    iso7816_rx_char_if u_if ();

    iso7816_rx_char #(
        .SYNC_STAGES(2)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .io_in      (io_in),
        .io_oe      (io_oe),
        .stb_rx     (stb_rx),
        .brg_sync   (brg_sync),
        .brg_run    (brg_run),
        .brg_txrx   (brg_txrx),
        .cfg_inverse(cfg_inverse),
        .en         (en),
        .out_if     (u_if)
    );

    always #5 clk = ~clk;

    // Baud generator model: phase restarts whenever it is not running.
    int brg_cnt = 0;
    always @(posedge clk) begin
        if (brg_sync || !brg_run) brg_cnt <= 0;
        else brg_cnt <= (brg_cnt == ETU - 1) ? 0 : brg_cnt + 1;
    end
    assign stb_rx = brg_run && (brg_cnt == ETU / 2 - 1);

    // Output monitor, sampled 1 time unit after each rising edge.
    int cyc = 0;
    int stb_cnt = 0, stb_wide = 0, sync_cnt = 0, oe_cnt = 0, oe_first = 0;
    logic [7:0] cap_data = '0;
    logic cap_perr = 1'b0, cap_ferr = 1'b0, prev_stb = 1'b0;
    always @(posedge clk) begin
        #1;
        cyc++;
        if (u_if.out_stb) begin
            stb_cnt++;
            if (prev_stb) stb_wide++;
            cap_data = u_if.out_data;
            cap_perr = u_if.out_perr;
            cap_ferr = u_if.out_ferr;
        end
        prev_stb = u_if.out_stb;
        if (brg_sync) sync_cnt++;
        if (io_oe) begin
            if (oe_cnt == 0) oe_first = cyc;
            oe_cnt++;
        end
    end

    int n_tests = 0;
    int n_fail = 0;
    int start_cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_mon();
        stb_cnt = 0;
        stb_wide = 0;
        sync_cnt = 0;
        oe_cnt = 0;
        oe_first = 0;
    endtask

    // bits[0] = start bit ... bits[9] = parity bit, then guard level for 3 etu.
    task automatic send_frame(input logic [9:0] bits, input logic guard);
        clear_mon();
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            io_in = bits[i];
            wait_clk(ETU);
        end
        io_in = guard;
        wait_clk(3 * ETU);
        io_in = 1'b1;
        wait_clk(2 * ETU);
    endtask

    initial begin
        wait_clk(5);
        check_eq("rst_io_oe", {31'd0, io_oe}, 32'd0);
        check_eq("rst_brg_sync", {31'd0, brg_sync}, 32'd0);
        check_eq("rst_brg_run", {31'd0, brg_run}, 32'd0);
        check_eq("rst_brg_txrx", {31'd0, brg_txrx}, 32'd0);
        check_eq("rst_out_stb", {31'd0, u_if.out_stb}, 32'd0);
        check_eq("rst_out_data", {24'd0, u_if.out_data}, 32'h00);
        check_eq("rst_out_perr", {31'd0, u_if.out_perr}, 32'd0);
        check_eq("rst_out_ferr", {31'd0, u_if.out_ferr}, 32'd0);
        rst = 1'b0;
        wait_clk(20);

        // Direct convention, 0x3B
        send_frame(10'b1001110110, 1'b1);
        check_eq("dir_stb_cnt", stb_cnt, 1);
        check_eq("dir_stb_width", stb_wide, 0);
        check_eq("dir_data", {24'd0, cap_data}, 32'h3B);
        check_eq("dir_perr", {31'd0, cap_perr}, 32'd0);
        check_eq("dir_ferr", {31'd0, cap_ferr}, 32'd0);
        check_eq("dir_io_oe", oe_cnt, 0);
        check_eq("dir_sync_cnt", sync_cnt, 1);
        check_eq("dir_run_idle", {31'd0, brg_run}, 32'd0);
        check_eq("dir_data_held", {24'd0, u_if.out_data}, 32'h3B);

        // Inverse convention, TS = 0x3F
        cfg_inverse = 1'b1;
        send_frame(10'b1000000110, 1'b1);
        check_eq("inv_stb_cnt", stb_cnt, 1);
        check_eq("inv_data", {24'd0, cap_data}, 32'h3F);
        check_eq("inv_perr", {31'd0, cap_perr}, 32'd0);
        cfg_inverse = 1'b0;

        // Parity error, 0x55 with parity bit 1
        send_frame(10'b1010101010, 1'b1);
        check_eq("par_stb_cnt", stb_cnt, 1);
        check_eq("par_data", {24'd0, cap_data}, 32'h55);
        check_eq("par_perr", {31'd0, cap_perr}, 32'd1);
        check_eq("par_ferr", {31'd0, cap_ferr}, 32'd0);
`ifdef ISO7816_RX_ERRSIG_EN
        check_eq("par_oe_len_ok", {31'd0, (oe_cnt >= ETU - 1) && (oe_cnt <= ETU + 1)}, 32'd1);
        check_eq("par_oe_start_ok", {31'd0, (oe_first - start_cyc >= 3900) &&
                                            (oe_first - start_cyc <= 3915)}, 32'd1);
`else
        check_eq("par_io_oe", oe_cnt, 0);
`endif

        // False start: 50 clk low pulse
        clear_mon();
        io_in = 1'b0;
        wait_clk(50);
        io_in = 1'b1;
        check_eq("fs_run_on", {31'd0, brg_run}, 32'd1);
        wait_clk(ETU);
        check_eq("fs_sync_cnt", sync_cnt, 1);
        check_eq("fs_run_off", {31'd0, brg_run}, 32'd0);
        check_eq("fs_stb_cnt", stb_cnt, 0);

        // Framing error: line low through the guard sample
        send_frame(10'b1001110110, 1'b0);
        check_eq("fe_stb_cnt", stb_cnt, 1);
        check_eq("fe_data", {24'd0, cap_data}, 32'h3B);
        check_eq("fe_ferr", {31'd0, cap_ferr}, 32'd1);
        check_eq("fe_perr", {31'd0, cap_perr}, 32'd0);

        // Reset mid-frame at bit 4
        clear_mon();
        io_in = 1'b0; wait_clk(ETU);
        io_in = 1'b1; wait_clk(2 * ETU);
        io_in = 1'b0; wait_clk(ETU);
        io_in = 1'b1; wait_clk(ETU / 2);
        check_eq("mr_run_before", {31'd0, brg_run}, 32'd1);
        rst = 1'b1;
        io_in = 1'b1;
        wait_clk(1);
        check_eq("mr_run", {31'd0, brg_run}, 32'd0);
        check_eq("mr_io_oe", {31'd0, io_oe}, 32'd0);
        check_eq("mr_out_stb", {31'd0, u_if.out_stb}, 32'd0);
        check_eq("mr_out_data", {24'd0, u_if.out_data}, 32'h00);
        check_eq("mr_out_perr", {31'd0, u_if.out_perr}, 32'd0);
        check_eq("mr_out_ferr", {31'd0, u_if.out_ferr}, 32'd0);
        rst = 1'b0;
        wait_clk(8 * ETU);
        check_eq("mr_no_stb", stb_cnt, 0);

        // Enable dropped mid-frame
        clear_mon();
        io_in = 1'b0; wait_clk(ETU);
        io_in = 1'b1; wait_clk(2 * ETU);
        en = 1'b0;
        wait_clk(1);
        check_eq("en_run_off", {31'd0, brg_run}, 32'd0);
        check_eq("en_io_oe", {31'd0, io_oe}, 32'd0);
        io_in = 1'b0; wait_clk(ETU);
        io_in = 1'b1; wait_clk(10 * ETU);
        check_eq("en_no_stb", stb_cnt, 0);
        check_eq("en_sync_once", sync_cnt, 1);
        en = 1'b1;
        wait_clk(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
